// File: rtl/led_pwm_driver.sv
// RGB LED PWM driver: three channel outputs sharing one duty level, with a
// boundary-aligned cross-fade between colour codes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// STEADY   | level tracks brightness, active_colour matches colour
// FADE_OUT | old colour dimming toward 0, new colour latched at level 0
// FADE_IN  | new colour ramping toward brightness
module led_pwm_driver #(
  parameter int PWM_BITS  = 8,
  parameter int FADE_STEP = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          colour,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                fade_en,
  output logic                led_r,
  output logic                led_g,
  output logic                led_b,
  output logic                busy
);

  typedef enum logic [1:0] {STEADY, FADE_OUT, FADE_IN} state_t;

  localparam logic [PWM_BITS-1:0] STEP = FADE_STEP[PWM_BITS-1:0];

  state_t              state;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] level;
  logic [2:0]          active_colour;
  logic                boundary;
  logic                duty_on;
  logic                fade_in_done;

  assign boundary = &pwm_cnt;
  assign duty_on  = pwm_cnt < level;
  // Covers both a normal final step and a brightness lowered below the ramp.
  assign fade_in_done = (level >= brightness) || ((brightness - level) <= STEP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= STEADY;
      pwm_cnt       <= '0;
      level         <= '0;
      active_colour <= 3'b000;
      led_r         <= 1'b0;
      led_g         <= 1'b0;
      led_b         <= 1'b0;
      busy          <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      led_r   <= active_colour[0] && duty_on;
      led_g   <= active_colour[1] && duty_on;
      led_b   <= active_colour[2] && duty_on;

      if (boundary) begin
        if (!fade_en) begin
          active_colour <= colour;
          level         <= brightness;
          state         <= STEADY;
          busy          <= 1'b0;
        end else begin
          case (state)
            STEADY: begin
              if (colour != active_colour) begin
                state <= FADE_OUT;
                busy  <= 1'b1;
              end else begin
                level <= brightness;
              end
            end
            FADE_OUT: begin
              // Step guarded by the compare, so the subtraction never wraps.
              if (level > STEP) begin
                level <= level - STEP;
              end else begin
                level         <= '0;
                active_colour <= colour;
                state         <= FADE_IN;
                busy          <= 1'b1;
              end
            end
            FADE_IN: begin
              if (colour != active_colour) begin
                state <= FADE_OUT;
                busy  <= 1'b1;
              end else if (fade_in_done) begin
                level <= brightness;
                state <= STEADY;
                busy  <= 1'b0;
              end else begin
                level <= level + STEP;
              end
            end
            default: begin
              state <= STEADY;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver: counts high cycles per PWM period and
// compares against hand-derived duty/busy sequences.
module tb_led_pwm_driver;

  logic       clk;
  logic       rst;
  logic [2:0] colour;
  logic [7:0] brightness;
  logic       fade_en;
  logic       led_r;
  logic       led_g;
  logic       led_b;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;
  int n_per = 0;

  led_pwm_driver #(.PWM_BITS(8), .FADE_STEP(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .colour     (colour),
    .brightness (brightness),
    .fade_en    (fade_en),
    .led_r      (led_r),
    .led_g      (led_g),
    .led_b      (led_b),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input int obs, input int want);
    n_chk++;
    if (obs != want) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, obs, want);
    end
  endtask

  // One full period; entry point is just after pwm_cnt became 0.
  task automatic run_period(input int er, input int eg, input int eb, input int ebsy);
    int nr, ng, nb, bs;
    string tag;
    nr = 0; ng = 0; nb = 0;
    bs = int'(busy);
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      nr += int'(led_r);
      ng += int'(led_g);
      nb += int'(led_b);
    end
    tag = $sformatf("p%0d", n_per);
    chk_val({tag, "_r"}, nr, er);
    chk_val({tag, "_g"}, ng, eg);
    chk_val({tag, "_b"}, nb, eb);
    chk_val({tag, "_busy"}, bs, ebsy);
    n_per++;
  endtask

  task automatic run_col(input int mask, input int lvl, input int ebsy);
    run_period(mask[0] ? lvl : 0, mask[1] ? lvl : 0, mask[2] ? lvl : 0, ebsy);
  endtask

  initial begin
    rst        = 1'b0;
    colour     = 3'd0;
    brightness = 8'd0;
    fade_en    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_r", int'(led_r), 0);
    chk_val("rst_g", int'(led_g), 0);
    chk_val("rst_b", int'(led_b), 0);
    chk_val("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;

    // Static PWM
    brightness = 8'd64;
    colour     = 3'd1;
    run_col(0, 0, 0);
    run_col(1, 64, 0);
    brightness = 8'd0;
    run_col(1, 64, 0);
    run_col(1, 0, 0);
    brightness = 8'd255;
    run_col(1, 0, 0);
    run_col(1, 255, 0);

    // Cross-fade red -> green
    fade_en = 1'b1;
    run_col(1, 255, 0);
    colour = 3'd2;
    run_col(1, 255, 0);
    run_col(1, 255, 1);
    for (int k = 1; k <= 15; k++) run_col(1, 255 - 16 * k, 1);
    run_col(2, 0, 1);
    for (int k = 1; k <= 15; k++) run_col(2, 16 * k, 1);
    run_col(2, 255, 0);

    // Interrupted fade-in: green at 128 redirected to blue
    fade_en = 1'b0;
    colour  = 3'd1;
    run_col(2, 255, 0);
    fade_en = 1'b1;
    colour  = 3'd2;
    run_col(1, 255, 0);
    run_col(1, 255, 1);
    for (int k = 1; k <= 15; k++) run_col(1, 255 - 16 * k, 1);
    run_col(2, 0, 1);
    for (int k = 1; k <= 7; k++) run_col(2, 16 * k, 1);
    colour = 3'd4;
    run_col(2, 128, 1);
    run_col(2, 128, 1);
    for (int k = 1; k <= 7; k++) run_col(2, 128 - 16 * k, 1);
    run_col(4, 0, 1);
    for (int k = 1; k <= 15; k++) run_col(4, 16 * k, 1);
    run_col(4, 255, 0);

    // Brightness drop mid fade-in
    fade_en    = 1'b0;
    colour     = 3'd1;
    brightness = 8'd0;
    run_col(4, 255, 0);
    fade_en    = 1'b1;
    colour     = 3'd2;
    brightness = 8'd255;
    run_col(1, 0, 0);
    run_col(1, 0, 1);
    run_col(2, 0, 1);
    for (int k = 1; k <= 5; k++) run_col(2, 16 * k, 1);
    brightness = 8'd32;
    run_col(2, 96, 1);
    run_col(2, 32, 0);
    run_col(2, 32, 0);

    // White: every cycle of one period against the compare
    fade_en    = 1'b0;
    colour     = 3'd7;
    brightness = 8'd100;
    run_col(2, 32, 0);
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      chk_val($sformatf("white_r%0d", i), int'(led_r), (i < 100) ? 1 : 0);
      chk_val($sformatf("white_g%0d", i), int'(led_g), (i < 100) ? 1 : 0);
      chk_val($sformatf("white_b%0d", i), int'(led_b), (i < 100) ? 1 : 0);
    end

    // Off with fade: dims out, then silent ramp on colour 0 until STEADY
    fade_en = 1'b1;
    colour  = 3'd0;
    run_col(7, 100, 0);
    run_col(7, 100, 1);
    for (int k = 1; k <= 6; k++) run_col(7, 100 - 16 * k, 1);
    run_col(0, 0, 1);
    for (int k = 1; k <= 6; k++) run_col(0, 0, 1);
    run_col(0, 0, 0);

    // Reset in the middle of a green fade-in
    fade_en    = 1'b0;
    brightness = 8'd0;
    run_col(0, 0, 0);
    fade_en    = 1'b1;
    colour     = 3'd2;
    brightness = 8'd255;
    run_col(0, 0, 0);
    run_col(0, 0, 1);
    run_col(2, 0, 1);
    run_col(2, 16, 1);
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk_val("pre_rst_g", int'(led_g), 1);
    chk_val("pre_rst_busy", int'(busy), 1);
    rst    = 1'b0;
    colour = 3'd0;
    #1;
    chk_val("mid_rst_r", int'(led_r), 0);
    chk_val("mid_rst_g", int'(led_g), 0);
    chk_val("mid_rst_b", int'(led_b), 0);
    chk_val("mid_rst_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_col(0, 0, 0);
    run_col(0, 0, 0);
    fade_en = 1'b0;
    colour  = 3'd1;
    run_col(0, 0, 0);
    run_col(1, 255, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
